// File: rtl/itcm_uart_loader.sv
// Serial boot loader: receives an 8N1 UART frame (A5, LEN, N words, XOR checksum)
// and writes the words into the ITCM while holding the core in reset.
module itcm_uart_loader #(
  parameter int unsigned CLKS_PER_BIT   = 1215,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 14_000_000
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        uart_rx,
  output logic        itcm_we,
  output logic [11:0] itcm_addr,
  output logic [31:0] itcm_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int BIT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(MAX_WORDS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  logic             sync1_q, sync2_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_sel_q, byte_sel_d;
  logic [23:0]      word_buf_q, word_buf_d;
  logic [7:0]       csum_q, csum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             we_q, we_d;
  logic [11:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // ---------------- byte receiver ----------------
  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !sync2_q) begin
          rx_state_d = RX_START;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (bit_cnt_q == BIT_W'(HALF_BIT - 1)) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          // A start bit that has gone high again by midpoint was a glitch.
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == BIT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d  = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == BIT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d    = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = sync2_q;
          frame_err_d  = !sync2_q;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- frame FSM ----------------
  logic active;
  logic last_word;
  logic [15:0] len_n;

  assign active    = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);
  assign len_n     = {rx_shift_q, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_sel_d = byte_sel_q;
    word_buf_d = word_buf_q;
    csum_d     = csum_q;
    tmo_d      = (!active || byte_valid_q) ? '0 : tmo_q + TMO_W'(1);
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (byte_valid_q && rx_shift_q == 8'hA5) begin
          state_d    = S_LEN_LO;
          done_d     = 1'b0;
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_sel_d = '0;
          csum_d     = '0;
        end
      end
      S_LEN_LO: begin
        if (byte_valid_q) begin
          len_d   = {8'h00, rx_shift_q};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (byte_valid_q) begin
          len_d = len_n;
          if (len_n != 16'd0 && 32'(len_n) <= MAX_WORDS) state_d = S_DATA;
          else                                           state_d = S_ERROR;
        end
      end
      S_DATA: begin
        if (byte_valid_q) begin
          csum_d     = csum_q ^ rx_shift_q;
          byte_sel_d = byte_sel_q + 2'd1;
          if (byte_sel_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = 12'({word_idx_q, 2'b00});
            wdata_d    = {rx_shift_q, word_buf_q};
            word_idx_d = word_idx_q + IDX_W'(1);
            if (last_word) state_d = S_CHECK;
          end else begin
            word_buf_d[8*byte_sel_q +: 8] = rx_shift_q;
          end
        end
      end
      S_CHECK: begin
        if (byte_valid_q) state_d = (rx_shift_q == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    // Line errors and stalls abort a load; neither coincides with a received byte.
    if (active && (frame_err_q ||
        (!byte_valid_q && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)))) begin
      state_d = S_ERROR;
    end
    if (state_d == S_DONE)  done_d = 1'b1;
    if (state_d == S_ERROR) err_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_sel_q   <= '0;
      word_buf_q   <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= uart_rx;
      sync2_q      <= sync1_q;
      rx_prev_q    <= sync2_q;
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_sel_q   <= byte_sel_d;
      word_buf_q   <= word_buf_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign itcm_we    = we_q;
  assign itcm_addr  = addr_q;
  assign itcm_wdata = wdata_q;
  assign core_hold  = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_ERROR};
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_itcm_uart_loader.sv
// Directed bench for itcm_uart_loader: a vector table of whole frames plus
// hand-written sequences for glitch, reload, framing, timeout and reset cases.
module tb_itcm_uart_loader;

  localparam int CPB = 8;
  localparam int MAXW = 1024;
  localparam int TMO = 400;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        uart_rx;
  logic        itcm_we;
  logic [11:0] itcm_addr;
  logic [31:0] itcm_wdata;
  logic        core_hold, load_done, load_error;

  int total = 0;
  int bad = 0;

  itcm_uart_loader #(
    .CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .cpu_rst(cpu_rst), .uart_rx(uart_rx),
    .itcm_we(itcm_we), .itcm_addr(itcm_addr), .itcm_wdata(itcm_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Write capture (monitor is the only writer of these).
  logic [11:0] cap_a [64];
  logic [31:0] cap_d [64];
  int wr_cnt = 0;
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (itcm_we) begin
      cap_a[wr_cnt % 64] <= itcm_addr;
      cap_d[wr_cnt % 64] <= itcm_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (itcm_we && prev_we) begin
      bad++;
      $display("FAIL we_back_to_back: got two consecutive write cycles, required at most one");
    end
    prev_we <= itcm_we;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  typedef struct packed {
    logic [127:0] bytes;
    logic [4:0]   nbytes;
    logic [1:0]   nwr;
    logic [11:0]  a0;
    logic [31:0]  d0;
    logic [11:0]  a1;
    logic [31:0]  d1;
    logic         done;
    logic         err;
    logic         hold;
  } vec_t;

  vec_t vecs [4];
  logic [127:0] good_frame;
  int base;

  task automatic send_frame(input logic [127:0] fr, input int first, input int n);
    for (int i = first; i < first + n; i++) send_byte(fr[8*i +: 8], 1'b1);
  endtask

  initial begin
    good_frame = 128'({8'h7C, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00,
                       8'h13, 8'h00, 8'h02, 8'hA5});
    vecs[0] = '{bytes: good_frame, nbytes: 5'd12, nwr: 2'd2,
                a0: 12'h000, d0: 32'h13, a1: 12'h004, d1: 32'h6F,
                done: 1'b1, err: 1'b0, hold: 1'b0};
    vecs[1] = '{bytes: 128'({8'h7D, good_frame[87:0]}), nbytes: 5'd12, nwr: 2'd2,
                a0: 12'h000, d0: 32'h13, a1: 12'h004, d1: 32'h6F,
                done: 1'b0, err: 1'b1, hold: 1'b1};
    vecs[2] = '{bytes: 128'({8'h04, 8'h01, 8'hA5}), nbytes: 5'd3, nwr: 2'd0,
                a0: 12'h0, d0: 32'h0, a1: 12'h0, d1: 32'h0,
                done: 1'b0, err: 1'b1, hold: 1'b1};
    vecs[3] = '{bytes: 128'({8'h00, 8'h00, 8'hA5}), nbytes: 5'd3, nwr: 2'd0,
                a0: 12'h0, d0: 32'h0, a1: 12'h0, d1: 32'h0,
                done: 1'b0, err: 1'b1, hold: 1'b1};

    cpu_rst = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_we", 32'(itcm_we), 32'd0);
    chk("rst_addr", 32'(itcm_addr), 32'd0);
    chk("rst_wdata", itcm_wdata, 32'd0);
    chk("rst_flags", 32'({core_hold, load_done, load_error}), 32'd0);
    cpu_rst = 1'b1;
    repeat (5) @(negedge clk);

    // 0.3-bit glitch in idle must not be taken as a byte.
    base = wr_cnt;
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    chk("glitch_flags", 32'({core_hold, load_done, load_error}), 32'd0);
    chk("glitch_writes", 32'(wr_cnt - base), 32'd0);
    $display("txn glitch: hold=%0b done=%0b err=%0b", core_hold, load_done, load_error);

    for (int v = 0; v < 4; v++) begin
      base = wr_cnt;
      send_byte(vecs[v].bytes[7:0], 1'b1);
      chk($sformatf("v%0d_hold_after_a5", v), 32'(core_hold), 32'd1);
      chk($sformatf("v%0d_flags_cleared", v), 32'({load_done, load_error}), 32'd0);
      send_frame(vecs[v].bytes, 1, int'(vecs[v].nbytes) - 1);
      chk($sformatf("v%0d_writes", v), 32'(wr_cnt - base), 32'(vecs[v].nwr));
      if (vecs[v].nwr == 2'd2) begin
        chk($sformatf("v%0d_a0", v), 32'(cap_a[base % 64]), 32'(vecs[v].a0));
        chk($sformatf("v%0d_d0", v), cap_d[base % 64], vecs[v].d0);
        chk($sformatf("v%0d_a1", v), 32'(cap_a[(base + 1) % 64]), 32'(vecs[v].a1));
        chk($sformatf("v%0d_d1", v), cap_d[(base + 1) % 64], vecs[v].d1);
      end
      chk($sformatf("v%0d_done", v), 32'(load_done), 32'(vecs[v].done));
      chk($sformatf("v%0d_err", v), 32'(load_error), 32'(vecs[v].err));
      chk($sformatf("v%0d_hold", v), 32'(core_hold), 32'(vecs[v].hold));
      $display("txn vector %0d: writes=%0d done=%0b err=%0b hold=%0b",
               v, wr_cnt - base, load_done, load_error, core_hold);
    end

    // Good load, then reload: load_done drops on A5 and returns at the end.
    send_frame(good_frame, 0, 12);
    chk("reload_first_done", 32'(load_done), 32'd1);
    base = wr_cnt;
    send_byte(8'hA5, 1'b1);
    chk("reload_done_dropped", 32'(load_done), 32'd0);
    chk("reload_hold", 32'(core_hold), 32'd1);
    send_frame(good_frame, 1, 11);
    chk("reload_done", 32'(load_done), 32'd1);
    chk("reload_hold_released", 32'(core_hold), 32'd0);
    chk("reload_writes", 32'(wr_cnt - base), 32'd2);
    $display("txn reload: writes=%0d done=%0b", wr_cnt - base, load_done);

    // Framing error on the third data byte.
    base = wr_cnt;
    send_frame(good_frame, 0, 5);
    send_byte(8'h00, 1'b0);
    chk("frame_err", 32'(load_error), 32'd1);
    chk("frame_err_hold", 32'(core_hold), 32'd1);
    chk("frame_err_writes", 32'(wr_cnt - base), 32'd0);
    $display("txn framing: writes=%0d err=%0b", wr_cnt - base, load_error);

    // Stall after five data bytes.
    base = wr_cnt;
    send_frame(good_frame, 0, 8);
    chk("tmo_before", 32'(load_error), 32'd0);
    chk("tmo_writes", 32'(wr_cnt - base), 32'd1);
    repeat (TMO + 1) @(negedge clk);
    chk("tmo_err", 32'(load_error), 32'd1);
    $display("txn timeout: err=%0b", load_error);

    // Reset after six data bytes, then a fresh load from address 0.
    base = wr_cnt;
    send_frame(good_frame, 0, 9);
    chk("rstmid_writes", 32'(wr_cnt - base), 32'd1);
    cpu_rst = 1'b0;
    @(negedge clk);
    chk("rstmid_outputs", 32'({itcm_we, itcm_addr, core_hold, load_done, load_error}), 32'd0);
    chk("rstmid_wdata", itcm_wdata, 32'd0);
    repeat (4) @(negedge clk);
    cpu_rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("rstmid_after_release", 32'({itcm_we, core_hold, load_done, load_error}), 32'd0);
    base = wr_cnt;
    send_frame(good_frame, 0, 12);
    chk("rstmid_reload_writes", 32'(wr_cnt - base), 32'd2);
    chk("rstmid_reload_a0", 32'(cap_a[base % 64]), 32'h000);
    chk("rstmid_reload_d0", cap_d[base % 64], 32'h13);
    chk("rstmid_reload_done", 32'(load_done), 32'd1);
    $display("txn reset_mid_frame: writes=%0d done=%0b", wr_cnt - base, load_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
